// File: rtl/x_uart_tx_arb_if.sv
// Requester and transmitter handshake bundle for the x_uart_tx arbiter.
// The arbiter takes the slave view; requesters and the transmitter take the master view.
interface x_uart_tx_arb_if #(
  parameter int unsigned p_req   = 4,
  parameter int unsigned p_width = 8
);
  logic [p_req-1:0]         req_valid;
  logic [p_req-1:0]         req_last;
  logic [p_req*p_width-1:0] req_data;
  logic [p_req-1:0]         req_accept;
  logic                     tx_valid;
  logic [p_width-1:0]       tx_data;
  logic                     tx_accept;

  modport slave (
    input  req_valid, req_last, req_data, tx_accept,
    output req_accept, tx_valid, tx_data
  );

  modport master (
    output req_valid, req_last, req_data, tx_accept,
    input  req_accept, tx_valid, tx_data
  );
endinterface

// File: rtl/x_uart_tx_arb.sv
// Round-robin arbiter feeding one x_uart_tx from p_req byte sources.
// Multi-byte messages lock the grant so messages never interleave on the line.
module x_uart_tx_arb #(
  parameter int unsigned p_req   = 4,
  parameter int unsigned p_width = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  x_uart_tx_arb_if.slave           bus,
  output logic [$clog2(p_req)-1:0] o_grant_id,
  output logic                     o_locked
);
  localparam int unsigned IdW = $clog2(p_req);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q, state_d;
  logic               tx_valid_q, tx_valid_d;
  logic [p_width-1:0] tx_data_q, tx_data_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic               locked_q, locked_d;
  logic [IdW-1:0]     win_id;
  logic               win_found;
  logic [p_req-1:0]   accept_c;
  logic [p_width-1:0] req_byte [p_req];

  // Pointer arithmetic that wraps at p_req-1, so unused codes never appear.
  function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] base, input int unsigned ofs);
    int unsigned s;
    s = 32'(base) + ofs;
    if (s >= p_req) s = s - p_req;
    return IdW'(s);
  endfunction

  for (genvar n = 0; n < p_req; n++) begin : g_unpack
    assign req_byte[n] = bus.req_data[n*p_width +: p_width];
  end

  // Winner search: the locked owner only, otherwise first valid after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = grant_q;
    if (locked_q) begin
      win_found = bus.req_valid[grant_q];
    end else begin
      for (int unsigned k = 1; k <= p_req; k++) begin
        if (!win_found && bus.req_valid[rr_idx(grant_q, k)]) begin
          win_found = 1'b1;
          win_id    = rr_idx(grant_q, k);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    locked_d   = locked_q;
    accept_c   = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          accept_c[win_id] = 1'b1;
          tx_valid_d       = 1'b1;
          tx_data_d        = req_byte[win_id];
          grant_d          = win_id;
          locked_d         = ~bus.req_last[win_id];
          state_d          = HOLD;
        end
      end
      HOLD: begin
        if (bus.tx_accept) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= IdW'(p_req - 1);
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
    end
  end

  // The accept pulse is combinational; hold it low while reset is asserted.
  assign bus.req_accept = accept_c & {p_req{~i_rst}};
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign o_grant_id     = grant_q;
  assign o_locked       = locked_q;
endmodule

// File: tb/tb_x_uart_tx_arb.sv
// Bench for x_uart_tx_arb: per-cycle model comparison plus directed scenarios.
module tb_x_uart_tx_arb;
  localparam int unsigned P   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned IdW = 2;
  localparam int          NLOG = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [IdW-1:0] grant_id;
  logic           locked;

  x_uart_tx_arb_if #(.p_req(P), .p_width(W)) bus ();

  x_uart_tx_arb #(.p_req(P), .p_width(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_grant_id (grant_id),
    .o_locked   (locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-requester byte queues feeding the request lines.
  logic [W-1:0] src_d [P][32];
  logic         src_l [P][32];
  int           src_wr [P] = '{default: 0};
  int           src_rd [P] = '{default: 0};

  task automatic push(input int n, input logic [W-1:0] d, input logic l);
    src_d[n][src_wr[n]] = d;
    src_l[n][src_wr[n]] = l;
    src_wr[n]++;
  endtask

  // Requester driver: pop on accept, present the next queued byte.
  initial begin
    logic [P-1:0] acc;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_accept;
      @(posedge clk);
      #1;
      for (int n = 0; n < P; n++) begin
        if (acc[n]) src_rd[n]++;
        if (src_rd[n] < src_wr[n]) begin
          bus.req_valid[n]         = 1'b1;
          bus.req_last[n]          = src_l[n][src_rd[n]];
          bus.req_data[n*W +: W]   = src_d[n][src_rd[n]];
        end else begin
          bus.req_valid[n]         = 1'b0;
          bus.req_last[n]          = 1'b0;
          bus.req_data[n*W +: W]   = '0;
        end
      end
    end
  end

  // Transfers seen on the serial side, in order.
  logic [W-1:0]   log_d [$];
  logic [IdW-1:0] log_g [$];

  // Behavioural model: one pending byte slot, a rotating priority pointer, a lock flag.
  initial begin
    bit           m_busy, n_busy;
    logic [W-1:0] m_data, n_data;
    int           m_gid, n_gid;
    bit           m_locked, n_locked;
    logic [P-1:0] exp_acc;
    int           win;
    m_busy = 0; m_data = '0; m_gid = P - 1; m_locked = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_data = '0; m_gid = P - 1; m_locked = 0;
      end else begin
        win = -1;
        if (!m_busy) begin
          if (m_locked) begin
            if (bus.req_valid[m_gid]) win = m_gid;
          end else begin
            for (int j = 1; j <= P; j++)
              if (win < 0 && bus.req_valid[(m_gid + j) % P]) win = (m_gid + j) % P;
          end
        end
        exp_acc = '0;
        if (win >= 0) exp_acc[win] = 1'b1;
        chk("req_accept", 32'(bus.req_accept), 32'(exp_acc));
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_busy));
        chk("tx_data", 32'(bus.tx_data), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("locked", 32'(locked), 32'(m_locked));
        if (bus.tx_valid && bus.tx_accept) begin
          log_d.push_back(bus.tx_data);
          log_g.push_back(grant_id);
        end
        n_busy = m_busy; n_data = m_data; n_gid = m_gid; n_locked = m_locked;
        if (m_busy && bus.tx_accept) begin
          n_busy = 0;
        end else if (win >= 0) begin
          n_busy   = 1;
          n_data   = bus.req_data[win*W +: W];
          n_gid    = win;
          n_locked = !bus.req_last[win];
        end
        @(posedge clk);
        if (!rst) begin
          m_busy = n_busy; m_data = n_data; m_gid = n_gid; m_locked = n_locked;
        end
      end
    end
  end

  task automatic wait_acc(input int n, input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_accept[n] && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("accept_seen_req%0d", n), 32'(bus.req_accept[n]), 32'd1);
  endtask

  task automatic wait_log(input int n, input int budget);
    int t;
    t = 0;
    while (log_d.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("log_len", 32'(log_d.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]   exp_d [NLOG];
    logic [IdW-1:0] exp_g [NLOG];
    int cnt;
    int bad;
    exp_d = '{8'hA5, 8'h11, 8'h12, 8'h13, 8'h10, 8'h21, 8'h22, 8'h23, 8'h20,
              8'h41, 8'h42, 8'h43, 8'h99, 8'h50, 8'h51, 8'h77, 8'hC3, 8'hD4,
              8'h5A, 8'h5B};
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
              2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2,
              2'd0, 2'd1};
    rst = 1'b1;
    bus.tx_accept = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd3);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_accept", 32'(bus.req_accept), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single byte
    push(0, 8'hA5, 1'b1);
    wait_acc(0, 20);
    @(negedge clk);
    chk("single_tx_valid", 32'(bus.tx_valid), 32'd1);
    chk("single_tx_data", 32'(bus.tx_data), 32'hA5);
    chk("single_grant", 32'(grant_id), 32'd0);
    chk("single_locked", 32'(locked), 32'd0);
    @(negedge clk);
    chk("single_drop", 32'(bus.tx_valid), 32'd0);
    wait_log(1, 50);

    // Round robin, two rounds, pointer starts after requester 0
    for (int n = 0; n < P; n++) begin
      push(n, 8'(8'h10 + n), 1'b1);
      push(n, 8'(8'h20 + n), 1'b1);
    end
    wait_log(9, 200);

    // Locked message from req2 with req1 waiting
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b0);
    push(2, 8'h43, 1'b1);
    wait_acc(2, 20);
    push(1, 8'h99, 1'b1);
    @(negedge clk);
    chk("lock_set", 32'(locked), 32'd1);
    chk("lock_grant", 32'(grant_id), 32'd2);
    wait_log(13, 200);

    // Lock stall: req3 owns the line but goes quiet
    push(3, 8'h50, 1'b0);
    wait_acc(3, 20);
    push(0, 8'h77, 1'b1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.req_accept[0]) cnt++;
    end
    chk("stall_no_accept", 32'(cnt), 32'd0);
    chk("stall_locked", 32'(locked), 32'd1);
    push(3, 8'h51, 1'b1);
    wait_log(16, 200);

    // Backpressure
    bus.tx_accept = 1'b0;
    push(1, 8'hC3, 1'b1);
    wait_acc(1, 20);
    push(2, 8'hD4, 1'b1);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hC3 || bus.req_accept !== '0) bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    bus.tx_accept = 1'b1;
    wait_log(18, 100);

    // Reset in the middle of a locked message
    bus.tx_accept = 1'b0;
    push(2, 8'hE1, 1'b0);
    wait_acc(2, 20);
    @(negedge clk);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd3);
    chk("mid_rst_accept", 32'(bus.req_accept), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    bus.tx_accept = 1'b1;
    @(negedge clk);
    push(0, 8'h5A, 1'b1);
    push(1, 8'h5B, 1'b1);
    wait_log(NLOG, 100);

    for (int i = 0; i < NLOG; i++) begin
      chk($sformatf("line_byte%0d", i),
          (i < log_d.size()) ? 32'(log_d[i]) : 32'hDEAD, 32'(exp_d[i]));
      chk($sformatf("line_grant%0d", i),
          (i < log_g.size()) ? 32'(log_g[i]) : 32'hDEAD, 32'(exp_g[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
